onehot_scan_decoder: RTL
========================

# onehot_scan_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two modes: direct decode of an input select, and autonomous scanning that rotates through the outputs at a prescaled rate and skips masked channels. It drives multiplexed loads such as seven-segment digit anodes and LED banks. It replaces hand-written fixed-width case decoders, and its output is registered for glitch-free pins.

## Interface
- SEL_W, 3: select/index width; output count OUT_N = 2**SEL_W (derived, not overridable).
- TICK_DIV, 100000: clock cycles per scan step; legal range >= 1.
- ACTIVE_LOW, 0: 1 inverts y (inactive = 1, active channel = 0).

- clk  input  1  system clock, rising-edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  global enable; 0 blanks y and freezes the index.
- mode  input  1  0 = direct decode of sel; 1 = scan.
- sel  input  SEL_W  channel select used in direct mode.
- mask  input  OUT_N  bit i = 1 forces channel i inactive and makes scan skip it.
- y  output  OUT_N  registered one-hot (or one-cold) channel drive.
- idx  output  SEL_W  registered current channel index.
- tick  output  1  registered one-cycle pulse marking a scan step.

## Operation
- State: idx register, prescaler pcnt (width clog2(TICK_DIV), min 1), y register, tick register.
- All registers update only on the rising edge of clk.
- Reset (reset_n = 0 at an edge): idx = 0, pcnt = 0, tick = 0, y = inactive (all 0, or all 1 if ACTIVE_LOW). Reset overrides every other input.
- en = 0:
  - idx holds and pcnt clears to 0.
  - tick = 0 and y = inactive.
- en = 1, mode = 0 (direct):
  - idx_next = sel.
  - pcnt = 0, tick = 0.
- en = 1, mode = 1 (scan):
  - pcnt counts 0..TICK_DIV-1 and wraps.
  - When pcnt == TICK_DIV-1: idx_next = the first unmasked index after idx, searching cyclically (OUT_N-1 wraps to 0). tick = 1 on that same edge.
  - If no other index is unmasked, idx_next = idx and tick still pulses.
  - On all other cycles, idx_next = idx and tick = 0.
- Output rule, applied on every edge with en = 1: y = onehot(idx_next) when mask[idx_next] = 0, else all-inactive. Polarity is then applied per ACTIVE_LOW.
- Consequence: y and idx always change on the same edge and stay consistent.
- mask = all ones: y stays inactive, idx holds, tick keeps pulsing.
- A scan entered or left on a masked idx shows an inactive y until the next step.
- Mode 0 -> 1: idx keeps its last value, pcnt starts from 0, and the first step occurs TICK_DIV edges later.
- Mode 1 -> 0: on the next edge idx = sel, pcnt = 0, and any pending partial period is discarded.
- mask and sel are sampled every edge, with no extra pipelining.

## Timing
- Direct-mode latency: a sel, en or mask change visible before edge k appears on y/idx after edge k (1 cycle).
- Scan period: exactly TICK_DIV cycles between tick pulses while en = 1 and mode = 1. With TICK_DIV = 1, tick is high every cycle and idx steps every cycle.
- tick is high in the cycle in which the new idx/y are first visible.
- Reset mid-scan: on the reset edge the outputs take their reset values. After release, the first step occurs TICK_DIV edges after the first non-reset edge.
- en deasserted mid-period: the partial count is lost; after re-enable a full TICK_DIV period elapses before the next step.
- No combinational path from inputs to y, idx or tick.

## Test plan
- Reset (SEL_W = 3, TICK_DIV = 4):
  - Hold reset_n = 0 for 3 edges -> y = 8'h00, idx = 0, tick = 0.
  - ACTIVE_LOW = 1 build -> y = 8'hFF.
- Direct mode:
  - en = 1, mode = 0, sel = 5 -> y = 8'b0010_0000 and idx = 5 after 1 edge.
  - Then mask[5] = 1 -> y = 8'h00 with idx still 5.
  - Then en = 0 -> y = 8'h00 and idx holds 5.
- Unmasked scan (mode = 1, mask = 0, from idx = 0):
  - idx steps 0,1,...,7,0 every 4 edges.
  - tick is high exactly in the cycles where idx changes; y = 8'h80 -> 8'h01 at the wrap.
- Masked scan:
  - mask = 8'b0110_0110 -> idx sequence 0,3,4,7,0.
  - mask = 8'hFF -> y = 8'h00, idx frozen, tick still every 4 cycles.
  - mask = ~(1 << idx) -> idx stays and y stays lit.
- Disruptions: assert each at pcnt = 2.
  - reset_n pulse -> next edge idx = 0, y = 8'h00; first step 4 edges after release.
  - Mode 1 -> 0 with sel = 6 -> next edge idx = 6, tick = 0.
  - Back to mode = 1 -> first step after 4 edges, to idx 7.
- TICK_DIV = 1 build:
  - Scan with mask = 0 -> idx increments every edge, tick constantly 1.
  - en = 0 for one cycle -> tick = 0 and idx holds for that cycle.

Source files
------------

// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - registered one-hot decoder with direct and masked autonomous scan modes
//
// Drives multiplexed loads (digit anodes, LED banks) from a registered one-hot
// or one-cold vector. Direct mode decodes sel; scan mode rotates through the
// unmasked channels once every TICK_DIV clock cycles.
//
// Parameters:
//   SEL_W       select / index width, output count is 2**SEL_W
//   TICK_DIV    clock cycles per scan step, >= 1
//   ACTIVE_LOW  1 = one-cold output (inactive 1, active channel 0)
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   en       global enable; low blanks y and freezes idx
//   mode     0 = direct decode of sel, 1 = scan
//   sel      channel select for direct mode
//   mask     bit i forces channel i inactive and makes scan skip it
//   y        registered channel drive
//   idx      registered current channel index
//   tick     registered one-cycle pulse on each scan step

module onehot_scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int TICK_DIV   = 100000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [(1 << SEL_W)-1:0]  mask,
    output logic [(1 << SEL_W)-1:0]  y,
    output logic [SEL_W-1:0]         idx,
    output logic                     tick
);

    localparam int OUT_N = 1 << SEL_W;

    // A single-cycle period still needs a one-bit counter so the terminal
    // compare below is well formed; it then simply stays at zero.
    localparam int PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [OUT_N-1:0]  Y_IDLE    = ACTIVE_LOW ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] pcnt_next;
    logic [SEL_W-1:0]  idx_next;
    logic [SEL_W-1:0]  scan_next;
    logic [SEL_W-1:0]  cand;
    logic              found;
    logic              tick_next;
    logic [OUT_N-1:0]  y_next;

    // Drive pattern for channel i: lit unless masked, then polarity applied.
    function automatic logic [OUT_N-1:0] drive_for(
        input logic [SEL_W-1:0] i,
        input logic [OUT_N-1:0] m
    );
        logic [OUT_N-1:0] oh;
        oh = '0;
        if (!m[i]) begin
            oh[i] = 1'b1;
        end
        return ACTIVE_LOW ? ~oh : oh;
    endfunction

    // Cyclic search for the first unmasked channel after idx. The offset
    // starts at 1 so the current channel is only kept when nothing else is
    // available; the SEL_W-bit add provides the wrap to channel 0.
    always_comb begin
        scan_next = idx;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k < OUT_N; k++) begin
            cand = idx + SEL_W'(k);
            if (!found && !mask[cand]) begin
                scan_next = cand;
                found     = 1'b1;
            end
        end
    end

    // Next-state selection. The output pattern is derived from idx_next so
    // y and idx always move together on the same edge.
    always_comb begin
        idx_next  = idx;
        pcnt_next = '0;
        tick_next = 1'b0;
        y_next    = Y_IDLE;
        if (en) begin
            if (!mode) begin
                idx_next = sel;
            end else if (pcnt == PCNT_LAST) begin
                idx_next  = scan_next;
                tick_next = 1'b1;
            end else begin
                pcnt_next = pcnt + PCNT_W'(1);
            end
            y_next = drive_for(idx_next, mask);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx  <= '0;
            pcnt <= '0;
            tick <= 1'b0;
            y    <= Y_IDLE;
        end else begin
            idx  <= idx_next;
            pcnt <= pcnt_next;
            tick <= tick_next;
            y    <= y_next;
        end
    end

endmodule
